reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares the single asynchronous control-register bus (en/rd/wr/be/addr/data) between two synchronous requesters, e.g. the host-bus synchronizer and the on-chip register-copy engine.
- Grants one transaction at a time with round-robin fairness.
- Sequences each access as setup, strobe and hold phases. The register bank clocks write data on the falling edge of wr, and only while en is high and rd is low.
- Returns read data to the requester with a one-cycle ack.

Parameters:
- ADDR_WIDTH, 16, register address width.
- DATA_WIDTH, 16, register data width.
- STROBE_CYCLES, 2, cycles rd/wr stays high. Legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 transaction request; level, held until ack0.
- we0  in  1  requester 0 direction; 1 = write, 0 = read. Sampled at grant.
- be0  in  2  requester 0 byte enables; sampled at grant.
- addr0  in  ADDR_WIDTH  requester 0 address; sampled at grant.
- wdata0  in  DATA_WIDTH  requester 0 write data; sampled at grant.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DATA_WIDTH  requester 0 read data; valid with ack0.
- req1, we1, be1, addr1, wdata1, ack1, rdata1: same definitions for requester 1.
- reg_en  out  1  register bus access enable.
- reg_rd  out  1  register bus read strobe.
- reg_wr  out  1  register bus write strobe; data is latched by the bank on its falling edge.
- reg_be  out  2  register bus byte enables.
- reg_addr  out  ADDR_WIDTH  register bus address.
- reg_wdata  out  DATA_WIDTH  data to register bank data_in.
- reg_rdata  in  DATA_WIDTH  data from register bank data_out.
- busy  out  1  high whenever state is not IDLE.
- grant  out  1  index of the owner of the current or last transaction.

Behaviour:
- Reset values: all outputs 0. State IDLE. Last-served pointer = 1, so requester 0 wins the first contention.
- Every bus output is driven from a flop; there are no combinational paths from req to the reg_* outputs.
- State IDLE:
  - If any req is high, choose the requester. With one request pending, that requester wins. With both pending, the requester not equal to the last-served pointer wins.
  - Latch we/be/addr/wdata of the winner into the transaction registers, set grant, update the pointer, go to SETUP.
- State SETUP (1 cycle):
  - reg_en=1; reg_addr/reg_be/reg_wdata driven from the transaction registers; reg_rd=reg_wr=0.
  - Load strobe counter = STROBE_CYCLES-1. Go to STROBE.
- State STROBE (STROBE_CYCLES cycles):
  - reg_en=1; reg_wr=we or reg_rd=~we, never both.
  - The counter decrements each cycle.
  - At count 0 on a read, capture reg_rdata into rdata of the owner. Go to HOLD.
- State HOLD (1 cycle):
  - reg_en=1, reg_rd=reg_wr=0. Address, data and be are still held, so the write edge sees stable en, addr and data.
  - ack of the owner = 1 for exactly this cycle. Next state IDLE.
- Latency: req sampled high at edge E0 → ack high in the cycle after edge E0+STROBE_CYCLES+1. For the default, ack is seen 4 cycles after the request edge.
- Throughput: minimum 1 idle cycle between transactions. Total cycles per access = STROBE_CYCLES+3.
- When STROBE_CYCLES=1, write data is latched on reg_wr falling at the STROBE→HOLD edge. For longer strobes, reg_wr stays high and the data is latched only at that same final falling edge.
- A requester must drop req in the cycle after ack, or it is treated as a new request. If it holds req continuously and the other requester is also pending, the two alternate strictly.
- Deasserting req after grant has no effect: the transaction completes and ack is still pulsed.
- Changing addr/wdata/we/be after grant has no effect.
- rdata_n holds its value until the next read completion for that requester. Writes and the other requester's reads do not modify it.
- Reset mid-transaction:
  - All reg_* outputs go to 0 immediately (asynchronously); state IDLE; no ack is issued.
  - Any falling edge on reg_wr during reset is masked by the bank's own reset.
  - The pointer returns to 1.
- An address beyond the bank size is passed through unchanged; decoding is the bank's responsibility.

Test Plan:
- Write: req0, we0=1, addr0=0x0004, wdata0=0xA5C3, be0=2'b11 → SETUP/STROBE/HOLD sequence with reg_wr high 2 cycles, reg_en high 4 cycles; ack0 pulses once; bank register 0x0004 reads 0xA5C3.
- Read: preload reg_rdata=0x1234, req1, we1=0, addr1=0x0009 → reg_rd high 2 cycles, reg_wr never high; ack1 with rdata1=0x1234; rdata0 unchanged.
- Contention: req0 and req1 rise on the same edge after reset → requester 0 served first (grant=0), then requester 1 (grant=1); each ack fires exactly once.
- Fairness: req0 held continuously, req1 asserted once → order 0,1,0. No requester is served twice while the other is pending.
- Byte enables: be0=2'b01, wdata0=0xFFEE over register value 0x1111 → register becomes 0x11EE; reg_be=2'b01 for the whole transaction.
- Reset in STROBE: assert reset in the 2nd STROBE cycle → reg_en/reg_wr/busy go to 0 immediately; no ack; after release, req0 is served first again.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sequencing two requesters onto the register bus
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [1:0]            be0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [1:0]            be1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  reg_en,
  output logic                  reg_rd,
  output logic                  reg_wr,
  output logic [1:0]            reg_be,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  last, last_nxt;
  logic                  txn_we, txn_we_nxt;
  logic                  win;
  logic                  grant_nxt, busy_nxt;
  logic                  en_nxt, rd_nxt, wr_nxt;
  logic                  ack0_nxt, ack1_nxt;
  logic [1:0]            be_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, rdata0_nxt, rdata1_nxt;

  // On contention the requester that was not served last wins.
  assign win = (req0 && req1) ? ~last : req1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    txn_we_nxt = txn_we;
    grant_nxt  = grant;
    be_nxt     = reg_be;
    addr_nxt   = reg_addr;
    wdata_nxt  = reg_wdata;
    rdata0_nxt = rdata0;
    rdata1_nxt = rdata1;
    en_nxt     = 1'b0;
    rd_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt  = SETUP;
          grant_nxt  = win;
          last_nxt   = win;
          txn_we_nxt = win ? we1 : we0;
          be_nxt     = win ? be1 : be0;
          addr_nxt   = win ? addr1 : addr0;
          wdata_nxt  = win ? wdata1 : wdata0;
          en_nxt     = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LOAD;
        en_nxt    = 1'b1;
        rd_nxt    = ~txn_we;
        wr_nxt    = txn_we;
      end
      STROBE: begin
        en_nxt = 1'b1;
        if (cnt == 4'd0) begin
          // Strobe drops here; the bank latches writes on this falling edge.
          state_nxt = HOLD;
          ack0_nxt  = ~grant;
          ack1_nxt  = grant;
          if (!txn_we) begin
            if (grant) rdata1_nxt = reg_rdata;
            else       rdata0_nxt = reg_rdata;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
          rd_nxt  = ~txn_we;
          wr_nxt  = txn_we;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      txn_we    <= 1'b0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      reg_en    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_be    <= 2'b00;
      reg_addr  <= '0;
      reg_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      txn_we    <= txn_we_nxt;
      grant     <= grant_nxt;
      busy      <= busy_nxt;
      reg_en    <= en_nxt;
      reg_rd    <= rd_nxt;
      reg_wr    <= wr_nxt;
      reg_be    <= be_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      rdata0    <= rdata0_nxt;
      rdata1    <= rdata1_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - randomized bench with transaction-level model and register bank
module tb_reg_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, we, ack, hold, e_ack;
  logic [1:0]    be [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata [2];
  logic          reg_en, reg_rd, reg_wr, busy, grant;
  logic [1:0]    reg_be;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .we0(we[0]), .be0(be[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .ack0(ack[0]), .rdata0(rdata[0]),
    .req1(req[1]), .we1(we[1]), .be1(be[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .ack1(ack[1]), .rdata1(rdata[1]),
    .reg_en(reg_en), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_be(reg_be),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .grant(grant)
  );

  // Register bank: 16 words, written on the falling edge of reg_wr.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_mem [16];
  logic          prev_wr = 1'b0;
  assign reg_rdata = mem[reg_addr[3:0]];

  // Transaction model: phase counts cycles since the grant edge, -1 when idle.
  int            phase = -1;
  logic          m_ptr, m_grant, m_we;
  logic [1:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];

  int n_checks = 0, n_fail = 0;
  int cnt_en, cnt_rd, cnt_wr, be_bad;
  int ack_order [$];
  logic rnd_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = -1; m_ptr = 1'b1; m_grant = 1'b0; m_we = 1'b0;
    m_be = 2'b00; m_addr = '0; m_wdata = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic model_step();
    logic w;
    if (phase >= 0) begin
      phase++;
      if (phase == SC + 1) begin
        if (m_we) begin
          for (int b = 0; b < 2; b++)
            if (m_be[b]) exp_mem[m_addr[3:0]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_rdata[m_grant] = mem[m_addr[3:0]];
        end
      end else if (phase == SC + 2) begin
        phase = -1;
      end
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? ~m_ptr : req[1];
      m_ptr = w; m_grant = w; m_we = we[w]; m_be = be[w];
      m_addr = addr[w]; m_wdata = wdata[w]; phase = 0;
    end
  endtask

  task automatic bank_step();
    if (prev_wr && !reg_wr && reg_en && !reg_rd && !reset) begin
      for (int b = 0; b < 2; b++)
        if (reg_be[b]) mem[reg_addr[3:0]][8*b +: 8] = reg_wdata[8*b +: 8];
    end
    prev_wr = reg_wr;
  endtask

  task automatic check_outputs();
    logic e_en, e_rd, e_wr;
    e_en  = (phase >= 0);
    e_rd  = e_en && !m_we && phase >= 1 && phase <= SC;
    e_wr  = e_en && m_we && phase >= 1 && phase <= SC;
    e_ack = (phase == SC + 1) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;
    chk("reg_en", reg_en, e_en);
    chk("reg_rd", reg_rd, e_rd);
    chk("reg_wr", reg_wr, e_wr);
    chk("busy", busy, e_en);
    chk("ack", ack, e_ack);
    chk("grant", grant, m_grant);
    chk("reg_addr", reg_addr, m_addr);
    chk("reg_be", reg_be, m_be);
    chk("reg_wdata", reg_wdata, m_wdata);
    chk("rdata0", rdata[0], m_rdata[0]);
    chk("rdata1", rdata[1], m_rdata[1]);
    if (phase == SC + 1 && m_we)
      chk("bank_write", mem[m_addr[3:0]], exp_mem[m_addr[3:0]]);
  endtask

  task automatic tally();
    cnt_en += int'(reg_en); cnt_rd += int'(reg_rd); cnt_wr += int'(reg_wr);
    if (ack[0]) ack_order.push_back(0);
    if (ack[1]) ack_order.push_back(1);
  endtask

  task automatic clear_counts();
    cnt_en = 0; cnt_rd = 0; cnt_wr = 0; be_bad = 0;
    ack_order.delete();
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    bank_step();
    check_outputs();
    tally();
  endtask

  task automatic new_payload(input int i);
    we[i]    = 1'($urandom_range(0, 1));
    be[i]    = 2'($urandom_range(0, 3));
    addr[i]  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    wdata[i] = DW'($urandom);
  endtask

  // Requesters hold req until ack, then drop it unless told to hold.
  task automatic agents();
    for (int i = 0; i < 2; i++) begin
      if (req[i] && e_ack[i]) begin
        if (hold[i]) new_payload(i);
        else req[i] = 1'b0;
      end else if (rnd_mode && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        new_payload(i);
      end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
        new_payload(i);
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      cycle();
      agents();
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    req = 2'b00; we = 2'b00; hold = 2'b00; e_ack = 2'b00;
    for (int i = 0; i < 2; i++) begin
      be[i] = 2'b00; addr[i] = '0; wdata[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      mem[i] = DW'($urandom);
      exp_mem[i] = mem[i];
    end
    model_reset();
    clear_counts();
    cycle();
    cycle();
    chk("reset_busy", busy, 1'b0);
    chk("reset_en", reg_en, 1'b0);
    chk("reset_rdata0", rdata[0], 16'h0000);
    reset = 1'b0;

    // Write
    clear_counts();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0004; wdata[0] = 16'hA5C3; be[0] = 2'b11;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (ack[0] && lat < 0) lat = k;
      agents();
    end
    chk("write_latency", lat, 4);
    chk("write_wr_cycles", cnt_wr, 2);
    chk("write_en_cycles", cnt_en, 4);
    chk("write_rd_cycles", cnt_rd, 0);
    chk("write_ack_count", ack_order.size(), 1);
    chk("write_bank", mem[4], 16'hA5C3);

    // Read
    clear_counts();
    mem[9] = 16'h1234; exp_mem[9] = 16'h1234;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0009; wdata[1] = 16'h0000; be[1] = 2'b11;
    run(8);
    chk("read_rd_cycles", cnt_rd, 2);
    chk("read_wr_cycles", cnt_wr, 0);
    chk("read_ack_count", ack_order.size(), 1);
    chk("read_rdata1", rdata[1], 16'h1234);
    chk("read_rdata0_kept", rdata[0], 16'h0000);

    // Contention: both rise together
    clear_counts();
    new_payload(0); new_payload(1);
    req = 2'b11;
    run(14);
    chk("contend_count", ack_order.size(), 2);
    chk("contend_first", ack_order[0], 0);
    chk("contend_second", ack_order[1], 1);

    // Fairness: req0 held continuously, req1 once
    clear_counts();
    hold[0] = 1'b1;
    new_payload(0); new_payload(1);
    req = 2'b11;
    for (int k = 0; k < 40 && ack_order.size() < 3; k++) begin
      cycle();
      agents();
    end
    hold[0] = 1'b0;
    req[0] = 1'b0;
    chk("fair_count", ack_order.size(), 3);
    chk("fair_0", ack_order[0], 0);
    chk("fair_1", ack_order[1], 1);
    chk("fair_2", ack_order[2], 0);
    run(6);

    // Byte enables
    clear_counts();
    mem[2] = 16'h1111; exp_mem[2] = 16'h1111;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0002; wdata[0] = 16'hFFEE; be[0] = 2'b01;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (reg_en && reg_be != 2'b01) be_bad++;
      agents();
    end
    chk("be_bus", be_bad, 0);
    chk("be_bank", mem[2], 16'h11EE);

    // Reset during the second strobe cycle
    clear_counts();
    mem[5] = 16'h0505; exp_mem[5] = 16'h0505;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'hBEEF; be[0] = 2'b11;
    cycle();
    cycle();
    @(posedge clk);
    model_step();
    #2 reset = 1'b1;
    #1;
    chk("rst_async_en", reg_en, 1'b0);
    chk("rst_async_wr", reg_wr, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    model_reset();
    req = 2'b00;
    @(negedge clk);
    bank_step();
    check_outputs();
    tally();
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_no_ack", ack_order.size(), 0);
    chk("rst_masked_write", mem[5], 16'h0505);
    clear_counts();
    new_payload(0); new_payload(1);
    req = 2'b11;
    for (int k = 0; k < 20 && ack_order.size() < 1; k++) begin
      cycle();
      agents();
    end
    chk("rst_then_first", ack_order[0], 0);
    chk("rst_then_count", ack_order.size(), 1);
    run(10);

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int blk = 0; blk < 20; blk++) begin
      hold = 2'($urandom_range(0, 3));
      run(100);
    end
    rnd_mode = 1'b0;
    hold = 2'b00;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
